// File: rtl/double_to_sig16b_if.sv
// rtl/double_to_sig16b_if.sv - start/stop handshake bundle for the double to 16-bit sign-magnitude converter
interface double_to_sig16b_if;
    logic        start;
    logic [63:0] double;
    logic [15:0] sig16b;
    logic        stop;

    // Requester side: issues operands, observes results
    modport master (
        output start,
        output double,
        input  sig16b,
        input  stop
    );

    // Converter side
    modport slave (
        input  start,
        input  double,
        output sig16b,
        output stop
    );
endinterface

// File: rtl/double_to_sig16b.sv
// rtl/double_to_sig16b.sv - iterative IEEE-754 double to 16-bit sign-magnitude converter (option: DOUBLE_TO_SIG16B_ROUND_EN)
module double_to_sig16b (
    input  logic              clk,
    input  logic              rst,
    double_to_sig16b_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Exponent field values bounding the directly convertible range 0 <= e <= 14
    localparam logic [10:0] EXP_ONE     = 11'd1023;  // e = 0
    localparam logic [10:0] EXP_MAX     = 11'd1037;  // e = 14
    localparam logic [10:0] EXP_HALF    = 11'd1022;  // e = -1
    localparam logic [10:0] EXP_SPECIAL = 11'h7FF;

    // A shift register image whose upper 15 bits read as full scale and guard 0
    localparam logic [15:0] SHREG_SAT   = 16'hFFFE;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sign;
    logic        w_sign_nxt;
    logic [15:0] r_shreg;
    logic [15:0] w_shreg_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [15:0] r_sig16b;
    logic [15:0] w_sig16b_nxt;
    logic        r_stop;
    logic        w_stop_nxt;

    logic [10:0] w_exp;
    logic        w_mant_nz;
    logic [15:0] w_load_shreg;
    logic [3:0]  w_load_cnt;
    logic [14:0] w_trunc;
    logic [14:0] w_mag;
    logic [15:0] w_result;

    // Classify the incoming operand; special cases preload the shift register
    // with their final image and a zero count so they finish in one cycle.
    always_comb begin
        w_exp        = bus.double[62:52];
        w_mant_nz    = |bus.double[51:0];
        w_load_shreg = {1'b1, bus.double[51:37]};
        // 14 - e = 1037 - exp; since 1037 = 13 mod 16, only the low nibble matters
        w_load_cnt   = 4'd13 - w_exp[3:0];
        if (w_exp == 11'd0) begin
            w_load_shreg = 16'h0000;
            w_load_cnt   = 4'd0;
        end else if (w_exp == EXP_SPECIAL) begin
            w_load_shreg = w_mant_nz ? 16'h0000 : SHREG_SAT;
            w_load_cnt   = 4'd0;
        end else if (w_exp > EXP_MAX) begin
            w_load_shreg = SHREG_SAT;
            w_load_cnt   = 4'd0;
        end else if (w_exp < EXP_ONE) begin
`ifdef DOUBLE_TO_SIG16B_ROUND_EN
            // e = -1 may round up to 1, so it is shifted the full 15 places
            if (w_exp != EXP_HALF) begin
                w_load_shreg = 16'h0000;
                w_load_cnt   = 4'd0;
            end
`else
            w_load_shreg = 16'h0000;
            w_load_cnt   = 4'd0;
`endif
        end
    end

`ifdef DOUBLE_TO_SIG16B_ROUND_EN
    logic [15:0] w_sum;

    // Round half away from zero on the magnitude, saturating on carry-out
    always_comb begin
        w_trunc = r_shreg[15:1];
        w_sum   = {1'b0, w_trunc} + {15'd0, r_shreg[0]};
        w_mag   = w_sum[15] ? 15'h7FFF : w_sum[14:0];
    end
`else
    // Truncate: the guard bit is dropped
    always_comb begin
        w_trunc = r_shreg[15:1];
        w_mag   = w_trunc;
    end
`endif

    // Attach the sign only to a non-zero magnitude so -0 is never emitted
    always_comb begin
        w_result = {(w_mag != 15'd0) & r_sign, w_mag};
    end

    // Next-state and datapath updates; start is only honoured in IDLE or DONE
    always_comb begin
        w_state_nxt  = r_state;
        w_sign_nxt   = r_sign;
        w_shreg_nxt  = r_shreg;
        w_cnt_nxt    = r_cnt;
        w_sig16b_nxt = r_sig16b;
        w_stop_nxt   = r_stop;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_sign_nxt  = bus.double[63];
                    w_shreg_nxt = w_load_shreg;
                    w_cnt_nxt   = w_load_cnt;
                    w_stop_nxt  = 1'b0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt != 4'd0) begin
                    w_shreg_nxt = r_shreg >> 1;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end else begin
                    w_sig16b_nxt = w_result;
                    w_stop_nxt   = 1'b1;
                    w_state_nxt  = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_shreg  <= 16'h0000;
            r_cnt    <= 4'd0;
            r_sig16b <= 16'h0000;
            r_stop   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sign   <= w_sign_nxt;
            r_shreg  <= w_shreg_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sig16b <= w_sig16b_nxt;
            r_stop   <= w_stop_nxt;
        end
    end

    assign bus.sig16b = r_sig16b;
    assign bus.stop   = r_stop;

endmodule

// File: doc/double_to_sig16b.md
# double_to_sig16b

Converts one IEEE-754 double-precision sample back to the 16-bit sign-magnitude sample format used at the codec boundary, using an iterative right-shift denormaliser. It sits directly downstream of the floating-point echo-cancellation datapath and is the inverse stage of the 16-bit-to-double converter at the input. Conversion takes 1 to 16 cycles depending on exponent, and is handshaked with a `start` pulse and a `stop` done flag.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE or DONE.
- `double`  input  64  IEEE-754 double operand; captured on accepted `start`.
- `sig16b`  output  16  result: bit 15 = sign, bits [14:0] = integer magnitude; registered.
- `stop`  output  1  high while `sig16b` holds a valid result; registered.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset values: `sig16b` = 0x0000, `stop` = 0, state = IDLE, internal registers = 0.
- Accept (`start`=1 in IDLE or DONE):
  - capture sign `s`;
  - compute unbiased exponent `e = double[62:52] - 1023`;
  - load 16-bit shift register `{1'b1, double[51:37]}`;
  - set `stop` <= 0;
  - go to SHIFT.
- Shift count `cnt = 14 - e` (4 bits) for 0 <= e <= 14.
- Special-case classification at accept (each enters SHIFT with `cnt` = 0 and a preset result):
  - `double[62:52]` = 0 (zero or denormal): result magnitude 0.
  - exponent field = 0x7FF and mantissa != 0 (NaN): result 0x0000.
  - exponent field = 0x7FF and mantissa = 0 (Inf), or e > 14: magnitude saturates to 0x7FFF.
  - e < 0: magnitude 0. Exception: with the rounding feature enabled, e = -1 uses `cnt` = 15.
- In SHIFT, each cycle:
  - if `cnt` != 0: shift register logically right by 1, decrement `cnt`;
  - if `cnt` = 0: magnitude = `reg[15:1]`, guard bit = `reg[0]`. Write `sig16b`, set `stop` <= 1, go to DONE.
- Sign rule: `sig16b[15]` = `s` if magnitude != 0, otherwise 0. Negative zero is never produced.
- DONE holds `sig16b` and `stop` until the next accepted `start` or reset.
- `start` while in SHIFT is ignored: no restart, no queueing.
- `double` is don't-care except in the cycle `start` is accepted.

## Timing
- Accept at edge N; `stop` rises at edge N+1+cnt.
- Latency range:
  - e = 14 and all special cases: 1 cycle;
  - e = 0: 15 cycles;
  - e = -1 with rounding enabled: 16 cycles.
- `stop` falls at the edge that accepts a new `start`. `sig16b` keeps its old value until the new result is written.
- Back-to-back: `start` held high in DONE is accepted on that same edge. Throughput is one conversion per latency+1 cycles at most.
- `rst` mid-conversion: aborts at that edge and returns to reset values. No result is produced.

## Configuration
- `DOUBLE_TO_SIG16B_ROUND_EN` defined:
  - final magnitude = `reg[15:1]` + guard bit (round half away from zero on magnitude);
  - saturates at 0x7FFF if the increment overflows;
  - e = -1 is converted with `cnt` = 15 instead of being forced to 0.
- Undefined: magnitude is truncated (guard bit discarded), and every e < 0 gives 0.
- Latency, handshake and special cases are otherwise identical in both builds.

## Test plan
- Reset, then idle 5 cycles -> `sig16b` = 0x0000, `stop` = 0 throughout.
- `double` = 0x408F400000000000 (1000.0), `start` at edge N -> `sig16b` = 0x03E8, `stop` rises at edge N+6.
- `double` = 0xBFF0000000000000 (-1.0) -> `sig16b` = 0x8001 after 15 cycles. Then 0x40E3880000000000 (40000.0) from DONE -> `stop` low for one cycle, then 0x7FFF one cycle after accept.
- `double` = 0x4004000000000000 (2.5) -> 0x0002 without the macro, 0x0003 with it. `double` = 0x3FE8000000000000 (0.75) -> 0x0000 without, 0x0001 with (16-cycle latency).
- Special values: 0x7FF8000000000000 (NaN) -> 0x0000; 0xFFF0000000000000 (-Inf) -> 0xFFFF; 0x8000000000000000 (-0.0) -> 0x0000. All 1-cycle latency.
- Accept 1.0 (0x3FF0000000000000), pulse `start` with another value at N+3, assert `rst` at N+8 -> second `start` ignored, `stop` never rises, and all outputs are 0 after edge N+8.
